// File: rtl/scan_seq_ctrl.sv
`default_nettype none
// ============================================================================
// scan_seq_ctrl : frame-scan sequencer for a position generator and fetch port
// Revision: 1.0
// ============================================================================
module scan_seq_ctrl #(
  parameter int DIM_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DIM_W-1:0]   cfg_max_x,
  input  logic [DIM_W-1:0]   cfg_max_y,
  output logic [DIM_W-1:0]   max_x,
  output logic [DIM_W-1:0]   max_y,
  output logic               new_trans,
  output logic               update_pos,
  input  logic               end_pos,
  output logic               fetch_req,
  input  logic               fetch_ack,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*DIM_W-1:0] pix_count
);

  localparam int                 TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   TMO_ONE  = TMO_W'(1);
  localparam logic [2*DIM_W-1:0] PIX_ONE  = (2*DIM_W)'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    FETCH   = 3'd2,
    ADVANCE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state_q;
  logic [DIM_W-1:0]   max_x_q;
  logic [DIM_W-1:0]   max_y_q;
  logic [2*DIM_W-1:0] pix_count_q;
  logic [2*DIM_W-1:0] pix_count_d;
  logic [TMO_W-1:0]   tmo_q;
  logic               new_trans_q;
  logic               update_pos_q;
  logic               fetch_req_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               cfg_zero;
  logic               xfer;

  // The pixel counter sticks at all-ones instead of wrapping.
  assign pix_count_d = (&pix_count_q) ? pix_count_q : pix_count_q + PIX_ONE;
  assign cfg_zero    = (cfg_max_x == '0) || (cfg_max_y == '0);
  assign xfer        = fetch_req_q && fetch_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      max_x_q      <= '0;
      max_y_q      <= '0;
      pix_count_q  <= '0;
      tmo_q        <= '0;
      new_trans_q  <= 1'b0;
      update_pos_q <= 1'b0;
      fetch_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      new_trans_q  <= 1'b0;
      update_pos_q <= 1'b0;
      fetch_req_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (cfg_zero) begin
              err_q <= 1'b1;
            end else begin
              max_x_q     <= cfg_max_x;
              max_y_q     <= cfg_max_y;
              pix_count_q <= '0;
              state_q     <= INIT;
              new_trans_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end
        INIT: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            state_q     <= FETCH;
            tmo_q       <= '0;
            fetch_req_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        FETCH: begin
          if (xfer) begin
            pix_count_q <= pix_count_d;
            if (abort) begin
              state_q <= IDLE;
            end else if (end_pos) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q      <= ADVANCE;
              update_pos_q <= 1'b1;
              busy_q       <= 1'b1;
            end
          end else if (abort) begin
            state_q <= IDLE;
          end else if (tmo_q == TMO_LAST) begin
            // This cycle is the last unacknowledged one the port may wait.
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            tmo_q       <= tmo_q + TMO_ONE;
            fetch_req_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ADVANCE: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            state_q     <= FETCH;
            tmo_q       <= '0;
            fetch_req_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign max_x      = max_x_q;
  assign max_y      = max_y_q;
  assign new_trans  = new_trans_q;
  assign update_pos = update_pos_q;
  assign fetch_req  = fetch_req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign pix_count  = pix_count_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_scan_seq_ctrl : self-checking bench for scan_seq_ctrl
// Revision: 1.0
// ============================================================================
module tb_scan_seq_ctrl;

  localparam int DIM_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int MAXT    = 2048;
  localparam int MAXP    = 1024;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [DIM_W-1:0]   cfg_max_x;
  logic [DIM_W-1:0]   cfg_max_y;
  logic [DIM_W-1:0]   max_x;
  logic [DIM_W-1:0]   max_y;
  logic               new_trans;
  logic               update_pos;
  logic               end_pos;
  logic               fetch_req;
  logic               fetch_ack;
  logic               busy;
  logic               done;
  logic               err;
  logic [2*DIM_W-1:0] pix_count;

  int n_checks = 0;
  int n_fail   = 0;
  int gen_pos  = 0;

  int dly      [1:MAXP];
  bit fr_plan  [0:MAXT-1];
  bit up_plan  [0:MAXT-1];
  bit ack_plan [0:MAXT-1];

  typedef struct packed {
    logic             st;
    logic             ab;
    logic [DIM_W-1:0] cx;
    logic [DIM_W-1:0] cy;
    logic             e_err;
    logic             e_busy;
    logic             e_nt;
    logic [DIM_W-1:0] e_mx;
    logic [DIM_W-1:0] e_my;
  } vec_t;

  vec_t vt [0:7];

  always #5 clk = ~clk;

  scan_seq_ctrl #(.DIM_W(DIM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_max_x (cfg_max_x),
    .cfg_max_y (cfg_max_y),
    .max_x     (max_x),
    .max_y     (max_y),
    .new_trans (new_trans),
    .update_pos(update_pos),
    .end_pos   (end_pos),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pix_count (pix_count)
  );

  // Raster position generator: linear pixel index within the latched frame.
  always @(posedge clk) begin
    if (rst || new_trans) gen_pos <= 0;
    else if (update_pos)  gen_pos <= gen_pos + 1;
  end
  assign end_pos = (gen_pos == int'(max_x) * int'(max_y) - 1);

  task automatic check(input string name, input int t, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 60)
        $display("FAIL %s (t=%0d): got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " new_trans"},  0, new_trans,  0);
    check({tag, " update_pos"}, 0, update_pos, 0);
    check({tag, " fetch_req"},  0, fetch_req,  0);
    check({tag, " busy"},       0, busy,       0);
    check({tag, " done"},       0, done,       0);
    check({tag, " err"},        0, err,        0);
    check({tag, " max_x"},      0, max_x,      0);
    check({tag, " max_y"},      0, max_y,      0);
    check({tag, " pix_count"},  0, pix_count,  0);
  endtask

  // Scan timeline model: pixel p is fetched for dly[p]+1 cycles starting two
  // cycles after the previous acknowledge; t=0 is the INIT cycle.
  task automatic run_scan(input string tag, input int nx, input int ny, input int ab,
                          input bit noise, output int done_at, output int pix_end);
    int n_pix, t, s, a, end_t, done_t, err_t, exp_pix, n_up_exp, n_up_act;
    n_pix = nx * ny;
    for (int i = 0; i < MAXT; i++) begin
      fr_plan[i] = 0; up_plan[i] = 0; ack_plan[i] = 0;
    end
    t = 1; done_t = -1; err_t = -1; end_t = 0;
    for (int p = 1; p <= n_pix; p++) begin
      s = t;
      if (dly[p] >= TIMEOUT) begin
        for (int u = s; u < s + TIMEOUT; u++) fr_plan[u] = 1;
        end_t = s + TIMEOUT;
        err_t = end_t;
        break;
      end
      a = s + dly[p];
      for (int u = s; u <= a; u++) fr_plan[u] = 1;
      ack_plan[a] = 1;
      if (p == n_pix) begin
        done_t = a + 1;
        end_t  = a + 2;
      end else begin
        up_plan[a + 1] = 1;
        t = a + 2;
      end
    end
    if (ab >= 0 && ab < end_t) begin
      if (ab < done_t) done_t = -1;
      err_t = -1;
      end_t = ab + 1;
    end
    n_up_exp = 0;
    for (int u = 0; u < end_t; u++) if (up_plan[u]) n_up_exp++;

    @(negedge clk);
    start = 1'b1; abort = 1'b0; fetch_ack = 1'b0;
    cfg_max_x = DIM_W'(nx); cfg_max_y = DIM_W'(ny);
    exp_pix = 0; n_up_act = 0; done_at = -1; pix_end = -1;
    for (int tt = 0; tt <= end_t + 2; tt++) begin
      @(negedge clk);
      check({tag, " busy"},       tt, busy,       (tt < end_t) ? 1 : 0);
      check({tag, " new_trans"},  tt, new_trans,  (tt == 0) ? 1 : 0);
      check({tag, " fetch_req"},  tt, fetch_req,  (fr_plan[tt] && tt < end_t) ? 1 : 0);
      check({tag, " update_pos"}, tt, update_pos, (up_plan[tt] && tt < end_t) ? 1 : 0);
      check({tag, " done"},       tt, done,       (tt == done_t) ? 1 : 0);
      check({tag, " err"},        tt, err,        (tt == err_t) ? 1 : 0);
      check({tag, " pix_count"},  tt, pix_count,  exp_pix);
      check({tag, " max_x"},      tt, max_x,      nx);
      check({tag, " max_y"},      tt, max_y,      ny);
      if (update_pos) n_up_act++;
      if (done && done_at < 0) done_at = tt;
      pix_end = int'(pix_count);
      abort = (tt == ab);
      if (tt < end_t && fr_plan[tt]) fetch_ack = ack_plan[tt];
      else fetch_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (tt < end_t && ack_plan[tt]) exp_pix++;
      if (noise && tt < end_t) begin
        start     = ($urandom_range(0, 3) == 0);
        cfg_max_x = DIM_W'($urandom);
        cfg_max_y = DIM_W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0; abort = 1'b0; fetch_ack = 1'b0;
    check({tag, " update_pos count"}, end_t, n_up_act, n_up_exp);
    check({tag, " done time"},        end_t, done_at,  done_t);
  endtask

  initial begin
    int d_at, p_end, nx, ny, ab, r;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fetch_ack = 1'b0;
    cfg_max_x = '0; cfg_max_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // IDLE-state response vectors, applied in order (max_x/max_y carry over).
    vt[0] = '{1'b0, 1'b0, 8'd0,   8'd0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0};
    vt[1] = '{1'b1, 1'b0, 8'd0,   8'd5, 1'b1, 1'b0, 1'b0, 8'd0,   8'd0};
    vt[2] = '{1'b1, 1'b1, 8'd3,   8'd4, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0};
    vt[3] = '{1'b1, 1'b0, 8'd3,   8'd4, 1'b0, 1'b1, 1'b1, 8'd3,   8'd4};
    vt[4] = '{1'b1, 1'b0, 8'd5,   8'd0, 1'b1, 1'b0, 1'b0, 8'd3,   8'd4};
    vt[5] = '{1'b0, 1'b1, 8'd7,   8'd7, 1'b0, 1'b0, 1'b0, 8'd3,   8'd4};
    vt[6] = '{1'b1, 1'b0, 8'd255, 8'd1, 1'b0, 1'b1, 1'b1, 8'd255, 8'd1};
    vt[7] = '{1'b1, 1'b0, 8'd0,   8'd0, 1'b1, 1'b0, 1'b0, 8'd255, 8'd1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = vt[i].st; abort = vt[i].ab;
      cfg_max_x = vt[i].cx; cfg_max_y = vt[i].cy;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("vec err",       i, err,       vt[i].e_err);
      check("vec busy",      i, busy,      vt[i].e_busy);
      check("vec new_trans", i, new_trans, vt[i].e_nt);
      check("vec max_x",     i, max_x,     vt[i].e_mx);
      check("vec max_y",     i, max_y,     vt[i].e_my);
      check("vec pix_count", i, pix_count, 0);
      if (vt[i].e_busy) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("vec abort->idle busy", i, busy, 0);
        check("vec abort no err",     i, err,  0);
      end
      @(negedge clk);
      check("vec err one cycle", i, err, 0);
    end

    // 5x5 frame, every fetch acknowledged at once.
    for (int p = 1; p <= MAXP; p++) dly[p] = 0;
    run_scan("5x5", 5, 5, -1, 1'b0, d_at, p_end);
    check("5x5 done at INIT+50", 0, d_at, 50);
    check("5x5 pix_count", 0, p_end, 25);

    // Wide frame with the largest tested dimension.
    run_scan("240x3", 240, 3, -1, 1'b1, d_at, p_end);
    check("240x3 done at INIT+1440", 0, d_at, 1440);
    check("240x3 pix_count", 0, p_end, 720);

    // Acknowledge withheld from pixel 3 onward.
    dly[3] = TIMEOUT;
    run_scan("timeout", 5, 5, -1, 1'b0, d_at, p_end);
    check("timeout no done", 0, d_at, -1);
    check("timeout pix_count", 0, p_end, 2);
    dly[3] = 0;

    // Acknowledge on the last permitted cycle is not a timeout.
    dly[2] = TIMEOUT - 1;
    run_scan("late ack", 2, 2, -1, 1'b0, d_at, p_end);
    check("late ack pix_count", 0, p_end, 4);
    dly[2] = 0;

    // Abort coincident with the final transfer.
    run_scan("abort final", 5, 5, 49, 1'b0, d_at, p_end);
    check("abort final no done", 0, d_at, -1);
    check("abort final pix_count", 0, p_end, 25);

    // Reset in the middle of pixel 10, with start and abort also asserted.
    @(negedge clk);
    start = 1'b1; cfg_max_x = 8'd5; cfg_max_y = 8'd5;
    for (int t = 0; t <= 19; t++) begin
      @(negedge clk);
      start = 1'b0;
      fetch_ack = 1'b1;
    end
    check("mid-scan fetch_req", 19, fetch_req, 1);
    check("mid-scan pix_count", 19, pix_count, 9);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check_all_zero("mid-scan reset");
    rst = 1'b0; start = 1'b0; abort = 1'b0; fetch_ack = 1'b0;
    run_scan("after reset", 5, 5, -1, 1'b0, d_at, p_end);
    check("after reset pix_count", 0, p_end, 25);

    // Randomised scans: stalls, timeouts, aborts, stray start/cfg/ack.
    for (int k = 0; k < 30; k++) begin
      nx = $urandom_range(1, 5);
      ny = $urandom_range(1, 5);
      for (int p = 1; p <= nx * ny; p++) begin
        r = $urandom_range(0, 59);
        if (r == 0)       dly[p] = TIMEOUT + $urandom_range(0, 2);
        else if (r == 1)  dly[p] = TIMEOUT - 1;
        else if (r < 20)  dly[p] = $urandom_range(1, 3);
        else              dly[p] = 0;
      end
      ab = ($urandom_range(0, 9) < 3) ? $urandom_range(0, 2 * nx * ny + 4) : -1;
      run_scan("random", nx, ny, ab, 1'b1, d_at, p_end);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
